// File: rtl/vga_pkg.sv
// Shared timing constants and types for the VGA scan generator.
package vga_pkg;

    // Default 640x480@60 timing, counted in pixels (horizontal) and lines (vertical)
    localparam int unsigned H_VISIBLE_DEF = 640;
    localparam int unsigned H_FRONT_DEF   = 16;
    localparam int unsigned H_SYNC_DEF    = 96;
    localparam int unsigned H_BACK_DEF    = 48;
    localparam int unsigned H_TOTAL_DEF   = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;

    localparam int unsigned V_VISIBLE_DEF = 480;
    localparam int unsigned V_FRONT_DEF   = 10;
    localparam int unsigned V_SYNC_DEF    = 2;
    localparam int unsigned V_BACK_DEF    = 33;
    localparam int unsigned V_TOTAL_DEF   = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

    // All scan counters are 10-bit unsigned
    localparam int unsigned CNT_W = 10;
    typedef logic [CNT_W-1:0] count_t;

    // Phase of one scan axis
    typedef enum logic [1:0] {
        VISIBLE = 2'd0,
        FRONT   = 2'd1,
        SYNC    = 2'd2,
        BACK    = 2'd3
    } phase_e;

endpackage

// File: rtl/vga_scan_if.sv
// Pixel request / DAC bundle between the scan generator and its neighbours.
interface vga_scan_if;
    import vga_pkg::*;

    logic [23:0] rgb_in;
    count_t      next_x;
    count_t      next_y;
    logic [7:0]  vga_r;
    logic [7:0]  vga_g;
    logic [7:0]  vga_b;
    logic        vga_hs;
    logic        vga_vs;
    logic        vga_blank_n;
    logic        vga_clk;
    logic        frame_tick;

    // Scan generator side
    modport master (
        input  rgb_in,
        output next_x, next_y, vga_r, vga_g, vga_b,
        output vga_hs, vga_vs, vga_blank_n, vga_clk, frame_tick
    );

    // Object logic / DAC side
    modport slave (
        output rgb_in,
        input  next_x, next_y, vga_r, vga_g, vga_b,
        input  vga_hs, vga_vs, vga_blank_n, vga_clk, frame_tick
    );

endinterface

// File: rtl/vga_axis.sv
// One scan axis: wrapping counter plus VISIBLE/FRONT/SYNC/BACK phase FSM.
module vga_axis
    import vga_pkg::*;
#(
    parameter int unsigned VISIBLE_LEN = H_VISIBLE_DEF,
    parameter int unsigned FRONT_LEN   = H_FRONT_DEF,
    parameter int unsigned SYNC_LEN    = H_SYNC_DEF,
    parameter int unsigned BACK_LEN    = H_BACK_DEF
) (
    input  logic   clock,
    input  logic   reset,
    input  logic   en,
    output count_t count,
    output phase_e phase,
    output logic   wrap
);

    // Last count value of each phase; the FSM moves on when leaving it
    localparam count_t LAST_VISIBLE = count_t'(VISIBLE_LEN - 1);
    localparam count_t LAST_FRONT   = count_t'(VISIBLE_LEN + FRONT_LEN - 1);
    localparam count_t LAST_SYNC    = count_t'(VISIBLE_LEN + FRONT_LEN + SYNC_LEN - 1);
    localparam count_t LAST_TOTAL   = count_t'(VISIBLE_LEN + FRONT_LEN + SYNC_LEN + BACK_LEN - 1);

    count_t count_q, count_d;
    phase_e phase_q, phase_d;

    // Next count and phase; both advance only on enabled cycles
    always_comb begin
        count_d = count_q;
        phase_d = phase_q;
        wrap    = en && (count_q == LAST_TOTAL);
        if (en) begin
            if (count_q == LAST_TOTAL) count_d = '0;
            else                       count_d = count_q + count_t'(1);
            case (phase_q)
                VISIBLE: if (count_q == LAST_VISIBLE) phase_d = FRONT;
                FRONT:   if (count_q == LAST_FRONT)   phase_d = SYNC;
                SYNC:    if (count_q == LAST_SYNC)    phase_d = BACK;
                BACK:    if (count_q == LAST_TOTAL)   phase_d = VISIBLE;
                default:                              phase_d = VISIBLE;
            endcase
        end
    end

    // Counter and phase state registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            phase_q <= VISIBLE;
        end else begin
            count_q <= count_d;
            phase_q <= phase_d;
        end
    end

    assign count = count_q;
    assign phase = phase_q;

endmodule

// File: rtl/vga_scan.sv
// VGA raster scan generator: pixel-rate counters, sync/blank and one-pixel colour pipeline.
module vga_scan
    import vga_pkg::*;
#(
    parameter int unsigned H_VISIBLE = H_VISIBLE_DEF,
    parameter int unsigned H_FRONT   = H_FRONT_DEF,
    parameter int unsigned H_SYNC    = H_SYNC_DEF,
    parameter int unsigned H_BACK    = H_BACK_DEF,
    parameter int unsigned V_VISIBLE = V_VISIBLE_DEF,
    parameter int unsigned V_FRONT   = V_FRONT_DEF,
    parameter int unsigned V_SYNC    = V_SYNC_DEF,
    parameter int unsigned V_BACK    = V_BACK_DEF
) (
    input  logic       clock,
    input  logic       reset,
    vga_scan_if.master vif
);

    logic   pix_en_q, pix_en_d;
    count_t h_count, v_count;
    phase_e h_phase, v_phase;
    logic   h_wrap, v_wrap, v_en;
    logic   both_visible;

    logic [7:0] vga_r_q, vga_r_d;
    logic [7:0] vga_g_q, vga_g_d;
    logic [7:0] vga_b_q, vga_b_d;
    logic       vga_blank_n_q, vga_blank_n_d;
    logic       vga_hs_q, vga_hs_d;
    logic       vga_vs_q, vga_vs_d;
    logic       frame_tick_q, frame_tick_d;

    vga_axis #(
        .VISIBLE_LEN (H_VISIBLE),
        .FRONT_LEN   (H_FRONT),
        .SYNC_LEN    (H_SYNC),
        .BACK_LEN    (H_BACK)
    ) u_h_axis (
        .clock (clock),
        .reset (reset),
        .en    (pix_en_q),
        .count (h_count),
        .phase (h_phase),
        .wrap  (h_wrap)
    );

    // Lines advance once per completed line, still only on a pixel edge
    assign v_en = h_wrap & pix_en_q;

    vga_axis #(
        .VISIBLE_LEN (V_VISIBLE),
        .FRONT_LEN   (V_FRONT),
        .SYNC_LEN    (V_SYNC),
        .BACK_LEN    (V_BACK)
    ) u_v_axis (
        .clock (clock),
        .reset (reset),
        .en    (v_en),
        .count (v_count),
        .phase (v_phase),
        .wrap  (v_wrap)
    );

    // Pixel enable divider and next values of the registered DAC outputs
    always_comb begin
        pix_en_d      = ~pix_en_q;
        both_visible  = (h_phase == VISIBLE) && (v_phase == VISIBLE);
        vga_r_d       = vga_r_q;
        vga_g_d       = vga_g_q;
        vga_b_d       = vga_b_q;
        vga_blank_n_d = vga_blank_n_q;
        vga_hs_d      = vga_hs_q;
        vga_vs_d      = vga_vs_q;
        // v_wrap already implies h_wrap and pix_en, so this is a single-clock pulse
        frame_tick_d  = v_wrap;
        if (pix_en_q) begin
            vga_r_d       = both_visible ? vif.rgb_in[23:16] : 8'h00;
            vga_g_d       = both_visible ? vif.rgb_in[15:8]  : 8'h00;
            vga_b_d       = both_visible ? vif.rgb_in[7:0]   : 8'h00;
            vga_blank_n_d = both_visible;
            vga_hs_d      = (h_phase != SYNC);
            vga_vs_d      = (v_phase != SYNC);
        end
    end

    // Output and divider registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pix_en_q      <= 1'b0;
            vga_r_q       <= 8'h00;
            vga_g_q       <= 8'h00;
            vga_b_q       <= 8'h00;
            vga_blank_n_q <= 1'b0;
            vga_hs_q      <= 1'b1;
            vga_vs_q      <= 1'b1;
            frame_tick_q  <= 1'b0;
        end else begin
            pix_en_q      <= pix_en_d;
            vga_r_q       <= vga_r_d;
            vga_g_q       <= vga_g_d;
            vga_b_q       <= vga_b_d;
            vga_blank_n_q <= vga_blank_n_d;
            vga_hs_q      <= vga_hs_d;
            vga_vs_q      <= vga_vs_d;
            frame_tick_q  <= frame_tick_d;
        end
    end

    // Coordinates requested from the object logic; zero outside the visible area
    assign vif.next_x      = (h_phase == VISIBLE) ? h_count : '0;
    assign vif.next_y      = (v_phase == VISIBLE) ? v_count : '0;
    assign vif.vga_r       = vga_r_q;
    assign vif.vga_g       = vga_g_q;
    assign vif.vga_b       = vga_b_q;
    assign vif.vga_blank_n = vga_blank_n_q;
    assign vif.vga_hs      = vga_hs_q;
    assign vif.vga_vs      = vga_vs_q;
    assign vif.vga_clk     = pix_en_q;
    assign vif.frame_tick  = frame_tick_q;

endmodule

// File: tb/tb_vga_scan.sv
// Bench for vga_scan: a reduced-timing instance checked pixel by pixel against a
// scoreboard, and a default-timing instance checked on line-level timing.
module tb_vga_scan;
    import vga_pkg::*;

    // Reduced timing so whole frames fit in a short run
    localparam int SHV = 16, SHF = 2, SHS = 4, SHB = 3, HT = SHV + SHF + SHS + SHB;
    localparam int SVV = 10, SVF = 1, SVS = 2, SVB = 2, VT = SVV + SVF + SVS + SVB;
    localparam int FRAME_CLK = 2 * HT * VT;
    localparam int SPOT_X = 8, SPOT_Y = 9;
    localparam logic [48:0] RESET_VAL = {24'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 10'd0};

    typedef struct packed {
        logic [23:0] rgb;
        logic        blank;
        logic        hs;
        logic        vs;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   mode  = 0;
    int   errors = 0;
    int   checks = 0;

    // Reference scan model of the reduced instance
    bit   m_pix, m_upd, m_tick;
    int   m_h, m_v;
    exp_t q[$];

    vga_scan_if sif ();
    vga_scan_if dif ();

    vga_scan #(
        .H_VISIBLE (SHV), .H_FRONT (SHF), .H_SYNC (SHS), .H_BACK (SHB),
        .V_VISIBLE (SVV), .V_FRONT (SVF), .V_SYNC (SVS), .V_BACK (SVB)
    ) u_small (
        .clock (clock),
        .reset (reset),
        .vif   (sif)
    );

    vga_scan u_dflt (
        .clock (clock),
        .reset (reset),
        .vif   (dif)
    );

    always #10 clock = ~clock;

    function automatic logic [23:0] rgb_for(int md, int x, int y);
        case (md)
            1:       return (x == SPOT_X && y == SPOT_Y) ? 24'hFFFFFF : 24'h000000;
            2:       return 24'h00FF00;
            3:       return {8'(x + 1), 8'(y + 1), 8'h5A};
            default: return 24'h000000;
        endcase
    endfunction

    // Object-area logic stand-ins
    assign sif.rgb_in = rgb_for(mode, int'(sif.next_x), int'(sif.next_y));
    assign dif.rgb_in = 24'h00FF00;

    // One clock: push the expected output of an update edge, advance the model, land on negedge
    task automatic step();
        exp_t e;
        bit   hv, vv;
        m_upd = m_pix;
        if (m_pix) begin
            hv      = (m_h < SHV);
            vv      = (m_v < SVV);
            e.rgb   = (hv && vv) ? rgb_for(mode, m_h, m_v) : 24'h0;
            e.blank = hv && vv;
            e.hs    = !(m_h >= SHV + SHF && m_h < SHV + SHF + SHS);
            e.vs    = !(m_v >= SVV + SVF && m_v < SVV + SVF + SVS);
            q.push_back(e);
        end
        @(posedge clock);
        m_tick = m_pix && (m_h == HT - 1) && (m_v == VT - 1);
        if (m_pix) begin
            if (m_h == HT - 1) begin
                m_h = 0;
                m_v = (m_v == VT - 1) ? 0 : m_v + 1;
            end else begin
                m_h = m_h + 1;
            end
        end
        m_pix = !m_pix;
        @(negedge clock);
    endtask

    task automatic release_reset();
        reset  = 1'b1;
        m_pix  = 1'b0;
        m_upd  = 1'b0;
        m_tick = 1'b0;
        m_h    = 0;
        m_v    = 0;
        q.delete();
    endtask

    // Run until the model has just finished a frame (unchecked pixels are dropped)
    task automatic align_frame();
        exp_t e;
        for (int i = 0; i < 2 * FRAME_CLK; i++) begin
            step();
            if (m_upd) e = q.pop_front();
            if (m_tick) break;
        end
    endtask

    task automatic test_reset();
        logic [48:0] got;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            checks++;
            if (sif.vga_clk !== 1'b0) begin
                errors++;
                $display("FAIL reset_vga_clk: got %b expected 0", sif.vga_clk);
            end
        end
        got = {sif.vga_r, sif.vga_g, sif.vga_b, sif.vga_blank_n, sif.vga_hs, sif.vga_vs,
               sif.vga_clk, sif.frame_tick, sif.next_x, sif.next_y};
        checks++;
        if (got !== RESET_VAL) begin
            errors++;
            $display("FAIL reset_small: got %h expected %h", got, RESET_VAL);
        end
        got = {dif.vga_r, dif.vga_g, dif.vga_b, dif.vga_blank_n, dif.vga_hs, dif.vga_vs,
               dif.vga_clk, dif.frame_tick, dif.next_x, dif.next_y};
        checks++;
        if (got !== RESET_VAL) begin
            errors++;
            $display("FAIL reset_default: got %h expected %h", got, RESET_VAL);
        end
        release_reset();
        $display("test_reset: done, checks=%0d errors=%0d", checks, errors);
    endtask

    // Default 640x480 timing over two lines, counted in clocks from reset release
    task automatic test_default_line();
        exp_t e;
        int first_low = -1, second_low = -1, low_cnt = 0, blank_cnt = 0, gff_cnt = 0;
        int g_bad = 0, vs_low = 0, tick_cnt = 0, clk_bad = 0, xy_bad = 0, ex, ey;
        logic prev_hs = 1'b1;
        for (int n = 1; n <= 3000; n++) begin
            step();
            if (m_upd) e = q.pop_front();
            if (dif.vga_clk !== n[0]) clk_bad++;
            ex = (n / 2) % 800;
            if (ex >= 640) ex = 0;
            ey = (n / 2) / 800;
            if (dif.next_x !== 10'(ex) || dif.next_y !== 10'(ey)) xy_bad++;
            if (prev_hs === 1'b1 && dif.vga_hs === 1'b0) begin
                if (first_low < 0)       first_low = n;
                else if (second_low < 0) second_low = n;
            end
            if (dif.vga_hs === 1'b0 && second_low < 0) low_cnt++;
            prev_hs = dif.vga_hs;
            if (n <= 1600) begin
                if (dif.vga_blank_n === 1'b1) blank_cnt++;
                if (dif.vga_g === 8'hFF)      gff_cnt++;
            end
            if (dif.vga_blank_n === 1'b1) begin
                if (dif.vga_g !== 8'hFF || {dif.vga_r, dif.vga_b} !== 16'h0) g_bad++;
            end else if ({dif.vga_r, dif.vga_g, dif.vga_b} !== 24'h0) begin
                g_bad++;
            end
            if (dif.vga_vs !== 1'b1) vs_low++;
            if (dif.frame_tick !== 1'b0) tick_cnt++;
        end
        checks++; if (first_low != 1314) begin errors++; $display("FAIL dflt_hs_start: got clock %0d expected 1314", first_low); end
        checks++; if (second_low - first_low != 1600) begin errors++; $display("FAIL dflt_line_period: got %0d expected 1600", second_low - first_low); end
        checks++; if (low_cnt != 192) begin errors++; $display("FAIL dflt_hs_width: got %0d expected 192", low_cnt); end
        checks++; if (blank_cnt != 1280) begin errors++; $display("FAIL dflt_blank_n_width: got %0d expected 1280", blank_cnt); end
        checks++; if (gff_cnt != 1280) begin errors++; $display("FAIL dflt_green_width: got %0d expected 1280", gff_cnt); end
        checks++; if (g_bad != 0) begin errors++; $display("FAIL dflt_green_blanking: got %0d bad clocks expected 0", g_bad); end
        checks++; if (vs_low != 0) begin errors++; $display("FAIL dflt_vs: got %0d low clocks expected 0", vs_low); end
        checks++; if (tick_cnt != 0) begin errors++; $display("FAIL dflt_frame_tick: got %0d ticks expected 0", tick_cnt); end
        checks++; if (clk_bad != 0) begin errors++; $display("FAIL dflt_vga_clk: got %0d bad clocks expected 0", clk_bad); end
        checks++; if (xy_bad != 0) begin errors++; $display("FAIL dflt_next_xy: got %0d bad clocks expected 0", xy_bad); end
        $display("test_default_line: done, checks=%0d errors=%0d", checks, errors);
    endtask

    // Coordinate-dependent colour through a full frame, every output every clock
    task automatic test_pattern();
        exp_t e, got;
        int   ex, ey;
        mode = 3;
        for (int n = 1; n <= FRAME_CLK + 50 && errors < 40; n++) begin
            step();
            if (m_upd) begin
                e   = q.pop_front();
                got = {sif.vga_r, sif.vga_g, sif.vga_b, sif.vga_blank_n, sif.vga_hs, sif.vga_vs};
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL pattern_pixel: got %h expected %h (model h=%0d v=%0d)", got, e, m_h, m_v);
                end
            end
            ex = (m_h < SHV) ? m_h : 0;
            ey = (m_v < SVV) ? m_v : 0;
            checks++;
            if ({sif.next_x, sif.next_y} !== {10'(ex), 10'(ey)}) begin
                errors++;
                $display("FAIL pattern_next_xy: got %0d,%0d expected %0d,%0d", sif.next_x, sif.next_y, ex, ey);
            end
            checks++;
            if ({sif.vga_clk, sif.frame_tick} !== {m_pix, m_tick}) begin
                errors++;
                $display("FAIL pattern_clk_tick: got %b%b expected %b%b", sif.vga_clk, sif.frame_tick, m_pix, m_tick);
            end
        end
        $display("test_pattern: done, checks=%0d errors=%0d", checks, errors);
    endtask

    // Single white pixel on the last visible line
    task automatic test_spot();
        exp_t e, got;
        int   r_ff = 0, pos = -1;
        mode = 1;
        align_frame();
        for (int n = 1; n <= FRAME_CLK && errors < 40; n++) begin
            step();
            if (m_upd) begin
                e   = q.pop_front();
                got = {sif.vga_r, sif.vga_g, sif.vga_b, sif.vga_blank_n, sif.vga_hs, sif.vga_vs};
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL spot_pixel: got %h expected %h (model h=%0d v=%0d)", got, e, m_h, m_v);
                end
            end
            if (sif.vga_r === 8'hFF) begin
                r_ff++;
                if (pos < 0) pos = n;
            end
        end
        checks++; if (r_ff != 2) begin errors++; $display("FAIL spot_width: got %0d clocks expected 2", r_ff); end
        checks++; if (pos != 2 * (SPOT_Y * HT + SPOT_X + 1)) begin errors++; $display("FAIL spot_position: got clock %0d expected %0d", pos, 2 * (SPOT_Y * HT + SPOT_X + 1)); end
        $display("test_spot: done, checks=%0d errors=%0d", checks, errors);
    endtask

    // Constant green must be masked everywhere outside the visible window
    task automatic test_green();
        exp_t e, got;
        int   g_ff = 0;
        mode = 2;
        align_frame();
        for (int n = 1; n <= FRAME_CLK && errors < 40; n++) begin
            step();
            if (m_upd) begin
                e   = q.pop_front();
                got = {sif.vga_r, sif.vga_g, sif.vga_b, sif.vga_blank_n, sif.vga_hs, sif.vga_vs};
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL green_pixel: got %h expected %h (model h=%0d v=%0d)", got, e, m_h, m_v);
                end
            end
            if (sif.vga_g === 8'hFF) g_ff++;
        end
        checks++; if (g_ff != 2 * SHV * SVV) begin errors++; $display("FAIL green_visible_count: got %0d expected %0d", g_ff, 2 * SHV * SVV); end
        $display("test_green: done, checks=%0d errors=%0d", checks, errors);
    endtask

    // Two frames: tick spacing, vertical and horizontal sync widths
    task automatic test_frame_timing();
        exp_t e, got;
        int   t1 = -1, t2 = -1, vs_low = 0, hs_low = 0, first_vs = -1;
        mode = 0;
        align_frame();
        for (int n = 1; n <= 2 * FRAME_CLK && errors < 40; n++) begin
            step();
            if (m_upd) begin
                e   = q.pop_front();
                got = {sif.vga_r, sif.vga_g, sif.vga_b, sif.vga_blank_n, sif.vga_hs, sif.vga_vs};
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL frame_pixel: got %h expected %h (model h=%0d v=%0d)", got, e, m_h, m_v);
                end
            end
            if (sif.frame_tick === 1'b1) begin
                if (t1 < 0) t1 = n;
                else if (t2 < 0) t2 = n;
            end
            if (sif.vga_vs === 1'b0) begin
                vs_low++;
                if (first_vs < 0) first_vs = n;
            end
            if (sif.vga_hs === 1'b0) hs_low++;
        end
        checks++; if (t1 != FRAME_CLK) begin errors++; $display("FAIL frame_tick_first: got clock %0d expected %0d", t1, FRAME_CLK); end
        checks++; if (t2 - t1 != FRAME_CLK) begin errors++; $display("FAIL frame_tick_spacing: got %0d expected %0d", t2 - t1, FRAME_CLK); end
        checks++; if (vs_low != 2 * 2 * SVS * HT) begin errors++; $display("FAIL frame_vs_width: got %0d expected %0d", vs_low, 2 * 2 * SVS * HT); end
        checks++; if (first_vs != 2 * ((SVV + SVF) * HT + 1)) begin errors++; $display("FAIL frame_vs_start: got clock %0d expected %0d", first_vs, 2 * ((SVV + SVF) * HT + 1)); end
        checks++; if (hs_low != 2 * VT * 2 * SHS) begin errors++; $display("FAIL frame_hs_width: got %0d expected %0d", hs_low, 2 * VT * 2 * SHS); end
        $display("test_frame_timing: done, checks=%0d errors=%0d", checks, errors);
    endtask

    // Asynchronous reset in the middle of the visible area, then restart from (0,0)
    task automatic test_reset_midframe();
        exp_t        e, got;
        logic [48:0] rv;
        int          t1 = -1;
        mode = 3;
        for (int i = 0; i < 2 * FRAME_CLK; i++) begin
            step();
            if (m_upd) e = q.pop_front();
            if (m_h == 10 && m_v == 5) break;
        end
        #3;
        reset = 1'b0;
        #1;
        rv = {sif.vga_r, sif.vga_g, sif.vga_b, sif.vga_blank_n, sif.vga_hs, sif.vga_vs,
              sif.vga_clk, sif.frame_tick, sif.next_x, sif.next_y};
        checks++;
        if (rv !== RESET_VAL) begin errors++; $display("FAIL midreset_async_small: got %h expected %h", rv, RESET_VAL); end
        rv = {dif.vga_r, dif.vga_g, dif.vga_b, dif.vga_blank_n, dif.vga_hs, dif.vga_vs,
              dif.vga_clk, dif.frame_tick, dif.next_x, dif.next_y};
        checks++;
        if (rv !== RESET_VAL) begin errors++; $display("FAIL midreset_async_default: got %h expected %h", rv, RESET_VAL); end
        repeat (3) @(posedge clock);
        @(negedge clock);
        rv = {sif.vga_r, sif.vga_g, sif.vga_b, sif.vga_blank_n, sif.vga_hs, sif.vga_vs,
              sif.vga_clk, sif.frame_tick, sif.next_x, sif.next_y};
        checks++;
        if (rv !== RESET_VAL) begin errors++; $display("FAIL midreset_held: got %h expected %h", rv, RESET_VAL); end
        release_reset();
        for (int n = 1; n <= FRAME_CLK + 50 && errors < 40; n++) begin
            step();
            if (n == 1) begin
                checks++;
                if ({sif.vga_blank_n, sif.vga_clk, sif.vga_hs, sif.next_x} !== {3'b011, 10'd0}) begin
                    errors++;
                    $display("FAIL midreset_first_edge: got blank=%b clk=%b hs=%b x=%0d expected blank=0 clk=1 hs=1 x=0",
                             sif.vga_blank_n, sif.vga_clk, sif.vga_hs, sif.next_x);
                end
            end
            if (m_upd) begin
                e   = q.pop_front();
                got = {sif.vga_r, sif.vga_g, sif.vga_b, sif.vga_blank_n, sif.vga_hs, sif.vga_vs};
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL midreset_pixel: got %h expected %h (model h=%0d v=%0d)", got, e, m_h, m_v);
                end
            end
            if (sif.frame_tick === 1'b1 && t1 < 0) t1 = n;
        end
        checks++; if (t1 != FRAME_CLK) begin errors++; $display("FAIL midreset_next_tick: got clock %0d expected %0d", t1, FRAME_CLK); end
        $display("test_reset_midframe: done, checks=%0d errors=%0d", checks, errors);
    endtask

    initial begin
        test_reset();
        test_default_line();
        test_pattern();
        test_spot();
        test_green();
        test_frame_timing();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time limit so the run always ends
    initial begin
        #2000000;
        $display("FAIL timeout: simulation still running at %0t", $time);
        $fatal(1, "time limit reached");
    end

endmodule

// File: doc/vga_scan.md
VGA_SCAN -- requirements
Module: vga_scan

Interface
REQ-001 Parameters (name, default, meaning), one per line:
 H_VISIBLE 640 active pixels per line; H_FRONT 16; H_SYNC 96; H_BACK 48 (line total 800)
 V_VISIBLE 480 active lines; V_FRONT 10; V_SYNC 2; V_BACK 33 (frame total 525)
REQ-002 Ports (name direction width meaning), clock and reset first:
 clock  in  1  50 MHz system clock
 reset  in  1  asynchronous, active-low reset
 rgb_in  in  24  colour for pixel (next_x,next_y), {R,G,B} 8 bits each, combinational from object area logic
 next_x  out  10  column of pixel whose colour is requested
 next_y  out  10  row of pixel whose colour is requested
 vga_r / vga_g / vga_b  out  8 each  DAC colour
 vga_hs  out  1  horizontal sync, active low
 vga_vs  out  1  vertical sync, active low
 vga_blank_n  out  1  high during visible area
 vga_clk  out  1  25 MHz DAC pixel clock
 frame_tick  out  1  one-clock pulse per frame, for game-object timers
REQ-003 The design SHALL use one clock domain (clock); reset is asynchronous and active-low.

Function
REQ-004 pix_en register SHALL toggle every clock; all counters and outputs except frame_tick update only on edges where pix_en==1.
REQ-005 vga_clk SHALL equal pix_en (rises one clock after each output update; data stable 20 ns before rise).
REQ-006 h_count SHALL count 0..799 and wrap to 0; v_count SHALL increment when h_count wraps, range 0..524, wrap to 0.
REQ-007 Horizontal phase FSM SHALL have states VISIBLE(h 0-639), FRONT(640-655), SYNC(656-751), BACK(752-799), transitions at those boundaries only; vertical FSM identical with V boundaries (0-479, 480-489, 490-491, 492-524).
REQ-008 next_x SHALL equal h_count while h VISIBLE, else 0; next_y SHALL equal v_count while v VISIBLE, else 0 (combinational from counters).
REQ-009 Output pipeline latency SHALL be exactly one pixel: on each pix_en edge, vga_r/g/b <= rgb_in if both FSMs VISIBLE else 0; vga_blank_n <= both VISIBLE; vga_hs <= ~(h SYNC); vga_vs <= ~(v SYNC).
REQ-010 frame_tick SHALL be high for exactly one clock, on the edge where counters wrap from (799,524) to (0,0).
REQ-011 rgb_in SHALL be ignored (output forced 0) whenever either axis is outside VISIBLE, including when rgb_in is nonzero.
REQ-012 All counter arithmetic SHALL be 10-bit unsigned; no count SHALL exceed its total-minus-one value.

Reset
REQ-013 While reset low: pix_en=0, h_count=0, v_count=0, both FSMs VISIBLE, vga_r/g/b=0, vga_blank_n=0, vga_hs=1, vga_vs=1, frame_tick=0.
REQ-014 Reset asserted mid-frame SHALL immediately force REQ-013 values; after release the first pix_en edge occurs on the second clock edge and scanning restarts at (0,0).

Structure
REQ-015 Package vga_pkg SHALL hold the timing constants, line/frame totals and the phase-state enumeration (VISIBLE, FRONT, SYNC, BACK).
REQ-016 One sub-module vga_axis (counter plus phase FSM, parameterised by four phase lengths, with enable input and wrap output) SHALL be instantiated twice: horizontal (enabled by pix_en) and vertical (enabled by horizontal wrap AND pix_en).

Verification
REQ-017 Reset release -> vga_clk toggles every clock, vga_hs=vga_vs=1, blank_n=0 until first pix_en edge; next_x=0, next_y=0.
REQ-018 Free run one line -> vga_hs low for exactly 96 pixels (192 clocks) starting 1 pixel after h_count=656; line period 1600 clocks.
REQ-019 Free run two frames -> frame_tick spacing exactly 840000 clocks; vga_vs low 2 lines (3200 clocks) starting after v_count=490.
REQ-020 rgb_in=0xFFFFFF only when next_x==320 and next_y==464 -> vga outputs 0xFF,0xFF,0xFF for exactly one pixel, one pixel after that coordinate; 0 elsewhere.
REQ-021 rgb_in held 0x00FF00 constantly -> vga_g=0 during all blanking pixels (h>=640 or v>=480), 0xFF during visible.
REQ-022 Assert reset at (h=400,v=200) for 3 clocks -> outputs take REQ-013 values asynchronously; after release scan restarts at (0,0) and next frame_tick follows 840000 clocks later.
